// File: rtl/bloom_pkg.sv
// Shared definitions for the bloom scan sequencer: core mode encodings,
// controller state enum and the default distance range.
package bloom_pkg;

    localparam int DEFAULT_DIST_WIDTH = 14;
    localparam int MAX_DIST           = (1 << DEFAULT_DIST_WIDTH) - 1;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_REF   = 2'b01;
    localparam logic [1:0] MODE_BLOOM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REF,
        ST_GAP,
        ST_BLOOM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bloom_scan_ctrl_if.sv
// Core-side control/status bus plus the result record handshake of the
// bloom scan sequencer. The master side is the sequencer.
interface bloom_scan_ctrl_if #(
    parameter int DIST_WIDTH = 14,
    parameter int CNT_WIDTH  = 6
);
    logic [1:0]            mode;
    logic [DIST_WIDTH-1:0] distance;
    logic                  contains_ref;
    logic                  ref_end;
    logic [DIST_WIDTH-1:0] ref_dist;
    logic                  contains_bloom;
    logic                  bloom_end;
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_has_ref;
    logic [DIST_WIDTH-1:0] res_ref_dist;
    logic [CNT_WIDTH-1:0]  res_bloom_cnt;
    logic                  res_timeout;

    modport master (
        output mode, distance, res_valid, res_has_ref, res_ref_dist,
               res_bloom_cnt, res_timeout,
        input  contains_ref, ref_end, ref_dist, contains_bloom, bloom_end,
               res_ready
    );

    modport slave (
        input  mode, distance, res_valid, res_has_ref, res_ref_dist,
               res_bloom_cnt, res_timeout,
        output contains_ref, ref_end, ref_dist, contains_bloom, bloom_end,
               res_ready
    );
endinterface

// File: rtl/bloom_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and saturates
// at TIMEOUT; expired stays high while the count sits at TIMEOUT.
module bloom_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != LIMIT)
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);
endmodule

// File: rtl/bloom_scan_ctrl.sv
// Sequencer in front of the block top: one reference search, then a bloom
// sweep over a window around ref_dist, returning one result record.
module bloom_scan_ctrl
    import bloom_pkg::*;
#(
    parameter int DIST_WIDTH  = 14,
    parameter int BLOOM_RANGE = 16,
    parameter int CNT_WIDTH   = 6,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    bloom_scan_ctrl_if.master        bus
);
    localparam int WW = DIST_WIDTH + 1;
    localparam logic [DIST_WIDTH:0] MAX_W   = {1'b0, {DIST_WIDTH{1'b1}}};
    localparam logic [DIST_WIDTH:0] RANGE_W = WW'(BLOOM_RANGE);

    state_t state, next_state;

    logic [DIST_WIDTH-1:0] cursor, hi, ref_q;
    logic [DIST_WIDTH-1:0] win_lo, win_hi;
    logic [DIST_WIDTH:0]   ref_w;
    logic                  has_ref_q, timeout_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  wd_clr, wd_en, expired;

    // Window bounds clamp at 0 and MAX; the extra bit keeps ref+R from wrapping.
    always_comb begin
        ref_w  = {1'b0, bus.ref_dist};
        win_lo = (ref_w >= RANGE_W) ? DIST_WIDTH'(ref_w - RANGE_W) : '0;
        win_hi = (ref_w <= MAX_W - RANGE_W) ? DIST_WIDTH'(ref_w + RANGE_W) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        bus.mode     = MODE_IDLE;
        bus.distance = '0;
        busy         = 1'b1;
        bus.res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) next_state = ST_REF;
            end
            ST_REF: begin
                bus.mode = MODE_REF;
                if (bus.ref_end)
                    next_state = bus.contains_ref ? ST_GAP : ST_DONE;
                else if (expired)
                    next_state = ST_DONE;
            end
            ST_GAP: begin
                bus.distance = cursor;
                if (cursor != ref_q)
                    next_state = ST_BLOOM;
                else if (cursor == hi)
                    next_state = ST_DONE;
            end
            ST_BLOOM: begin
                bus.mode     = MODE_BLOOM;
                bus.distance = cursor;
                if (bus.bloom_end)
                    next_state = (cursor == hi) ? ST_DONE : ST_GAP;
                else if (expired)
                    next_state = ST_DONE;
            end
            ST_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign wd_en  = (state == ST_REF) || (state == ST_BLOOM);
    assign wd_clr = (next_state != state) &&
                    (next_state == ST_REF || next_state == ST_BLOOM);

    bloom_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor    <= '0;
            hi        <= '0;
            ref_q     <= '0;
            has_ref_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    cursor    <= '0;
                    hi        <= '0;
                    ref_q     <= '0;
                    has_ref_q <= 1'b0;
                    timeout_q <= 1'b0;
                    cnt_q     <= '0;
                end
                ST_REF: begin
                    if (bus.ref_end) begin
                        if (bus.contains_ref) begin
                            has_ref_q <= 1'b1;
                            ref_q     <= bus.ref_dist;
                            cursor    <= win_lo;
                            hi        <= win_hi;
                        end
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                    end
                end
                // Skipped reference point: advance unless it closes the window.
                ST_GAP: if (cursor == ref_q && cursor != hi) cursor <= cursor + 1'b1;
                ST_BLOOM: begin
                    if (bus.bloom_end) begin
                        if (bus.contains_bloom && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        if (cursor != hi) cursor <= cursor + 1'b1;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_has_ref   = has_ref_q;
    assign bus.res_ref_dist  = ref_q;
    assign bus.res_bloom_cnt = cnt_q;
    assign bus.res_timeout   = timeout_q;
endmodule
